// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one in-order memory port between several
// request/response stream pairs. Requests are granted round-robin and
// passed through combinationally. The index of each granted requester is
// recorded in a small in-order tracking queue, and the head of that queue
// steers each returning memory response to the port that issued the request.
//
// Message layouts, flattened into plain bit vectors:
//   request  (77b): {type[76:74], opaque[73:66], addr[65:34], len[33:32], data[31:0]}
//   response (47b): {type[46:44], opaque[43:36], test[35:34], len[33:32], data[31:0]}
module mem_req_arbiter #(
  parameter int p_num_reqs   = 2,
  parameter int p_max_outst  = 4,
  parameter int p_req_nbits  = 77,
  parameter int p_resp_nbits = 47
) (
  input  logic                                      clk,
  input  logic                                      reset,

  input  logic [p_num_reqs-1:0][p_req_nbits-1:0]    req_msg,
  input  logic [p_num_reqs-1:0]                     req_val,
  output logic [p_num_reqs-1:0]                     req_rdy,

  output logic [p_num_reqs-1:0][p_resp_nbits-1:0]   resp_msg,
  output logic [p_num_reqs-1:0]                     resp_val,
  input  logic [p_num_reqs-1:0]                     resp_rdy,

  output logic [p_req_nbits-1:0]                    mem_req_msg,
  output logic                                      mem_req_val,
  input  logic                                      mem_req_rdy,

  input  logic [p_resp_nbits-1:0]                   mem_resp_msg,
  input  logic                                      mem_resp_val,
  output logic                                      mem_resp_rdy,

  output logic [$clog2(p_max_outst):0]              num_outst
);

  localparam int RW = $clog2(p_num_reqs);
  localparam int PW = (p_max_outst > 1) ? $clog2(p_max_outst) : 1;
  localparam int CW = $clog2(p_max_outst) + 1;

  logic [RW-1:0] rr_ptr;
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [CW-1:0] count;
  logic [RW-1:0] track_q [p_max_outst];

  logic [RW-1:0] winner;
  logic          any_val;
  logic          can_issue;
  logic          req_fire;
  logic          resp_fire;
  logic          q_nonempty;
  logic [RW-1:0] head_idx;
  logic [RW-1:0] rr_next;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    int idx;
    winner  = '0;
    any_val = 1'b0;
    idx     = 0;
    for (int off = 0; off < p_num_reqs; off++) begin
      idx = (int'(rr_ptr) + off) % p_num_reqs;
      if (!any_val && req_val[idx]) begin
        winner  = RW'(idx);
        any_val = 1'b1;
      end
    end
  end

  // Grant path: the registered count gates issue, so a same-cycle pop never unblocks a full queue.
  always_comb begin
    can_issue   = (count < CW'(p_max_outst));
    mem_req_val = any_val && can_issue;
    mem_req_msg = req_msg[winner];
    req_fire    = mem_req_val && mem_req_rdy;
    rr_next     = RW'((int'(winner) + 1) % p_num_reqs);
    for (int i = 0; i < p_num_reqs; i++) begin
      req_rdy[i] = any_val && (winner == RW'(i)) && can_issue && mem_req_rdy;
    end
  end

  // Response steering: only the queue head sees valid; a response with nothing tracked stays stalled.
  always_comb begin
    q_nonempty   = (count != '0);
    head_idx     = track_q[head_ptr];
    mem_resp_rdy = q_nonempty && resp_rdy[head_idx];
    resp_fire    = mem_resp_val && mem_resp_rdy;
    for (int i = 0; i < p_num_reqs; i++) begin
      resp_msg[i] = mem_resp_msg;
      resp_val[i] = q_nonempty && (head_idx == RW'(i)) && mem_resp_val;
    end
  end

  // Arbitration pointer and tracking-queue bookkeeping; a stalled winner keeps its priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (req_fire) begin
        rr_ptr   <= rr_next;
        tail_ptr <= (tail_ptr == PW'(p_max_outst - 1)) ? '0 : tail_ptr + 1'b1;
      end
      if (resp_fire) begin
        head_ptr <= (head_ptr == PW'(p_max_outst - 1)) ? '0 : head_ptr + 1'b1;
      end
      if (req_fire && !resp_fire) begin
        count <= count + 1'b1;
      end else if (resp_fire && !req_fire) begin
        count <= count - 1'b1;
      end
    end
  end

  // Tracking storage needs no reset: entries are only read while count says they are live.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      track_q[tail_ptr] <= winner;
    end
  end

  assign num_outst = count;

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Shares one in-order memory port (cache or test memory) between `p_num_reqs` processor-side request/response stream pairs, e.g. the imem and dmem ports of one core, or the ports of several cores in the multicore build. Requests are granted round-robin, one message per cycle, and passed through combinationally. Each granted requester's index is recorded in an in-order tracking queue, and that queue steers each memory response back to the port that issued the request. The block sits between the processors' bypass request queues / drop units and the shared memory.

## Interface
- `p_num_reqs`, default 2: number of requester ports, range 2..8.
- `p_max_outst`, default 4: maximum number of outstanding memory requests; also the tracking queue depth; power of two, range 1..16.
- `clk` input, 1 bit: clock.
- `reset` input, 1 bit: reset, asynchronous and active-low.
- `req_msg` input, `mem_req_4B_t` [p_num_reqs]: per-requester request message.
- `req_val` input, [p_num_reqs]: per-requester request valid.
- `req_rdy` output, [p_num_reqs]: per-requester request ready.
- `resp_msg` output, `mem_resp_4B_t` [p_num_reqs]: per-requester response message.
- `resp_val` output, [p_num_reqs]: per-requester response valid.
- `resp_rdy` input, [p_num_reqs]: per-requester response ready.
- `mem_req_msg` output, `mem_req_4B_t`: request to the shared memory.
- `mem_req_val` output, 1 bit: memory request valid.
- `mem_req_rdy` input, 1 bit: memory request ready.
- `mem_resp_msg` input, `mem_resp_4B_t`: response from the shared memory.
- `mem_resp_val` input, 1 bit: memory response valid.
- `mem_resp_rdy` output, 1 bit: memory response ready.
- `num_outst` output, $clog2(p_max_outst)+1 bits: current number of outstanding requests.

## Operation
- **State:**
  - round-robin pointer `rr_ptr`, $clog2(p_num_reqs) bits;
  - tracking queue of requester indices, a circular buffer with head/tail pointers and a count;
  - no other registers.
- **Request arbitration (combinational):**
  - `can_issue` = count < p_max_outst.
  - The winner is the first index i with `req_val[i]` set, searching from `rr_ptr` upward with wrap-around.
  - `mem_req_val` = any(`req_val`) & `can_issue`.
  - `mem_req_msg` = `req_msg[winner]`, unmodified; the opaque field passes through.
  - `req_rdy[i]` = (i == winner) & `can_issue` & `mem_req_rdy`. `req_rdy` is 0 for every non-winner.
- **Request fire:** `mem_req_val & mem_req_rdy`. On a fire:
  - the winner index is pushed at the tail of the tracking queue;
  - `rr_ptr` <= (winner + 1) mod p_num_reqs.
- **No fire:** `rr_ptr` holds. A granted requester that is stalled by `mem_req_rdy` keeps its priority.
- **Response routing (combinational):**
  - `head` = index at the front of the tracking queue.
  - If the tracking queue is non-empty:
    - `resp_val[head]` = `mem_resp_val`;
    - `resp_msg[head]` = `mem_resp_msg`;
    - `mem_resp_rdy` = `resp_rdy[head]`.
  - If the tracking queue is empty, `mem_resp_rdy` = 0. A stray response is left stalled, never dropped.
  - `resp_val` is 0 for every non-head port.
  - Every `resp_msg` port is driven with `mem_resp_msg`. Only the head port has `resp_val` set.
- **Response fire:** `mem_resp_val & mem_resp_rdy` pops the tracking queue head.
- **Memory ordering:** memory responses must return in request order. The block relies on this and does not check opaque values.
- **Count update:** count' = count + req_fire − resp_fire.
  - A simultaneous push and pop leaves the count unchanged.
  - `can_issue` uses the registered count, so a pop in the same cycle does not unblock a request when the queue is full.
- **Pointer wrap:** head and tail pointers wrap modulo p_max_outst.

## Timing
- Zero-cycle latency through the arbiter for requests and for responses; no registers on the data paths.
- `rr_ptr`, the queue pointers and the count update on the rising `clk` edge.
- Reset (`reset` low, asynchronous):
  - `rr_ptr` = 0, count = 0, head = tail = 0;
  - therefore `mem_req_val` = 0 unless some `req_val` is high, all `resp_val` = 0, `mem_resp_rdy` = 0, `num_outst` = 0.
- Reset mid-operation discards all tracking state. Responses still in flight after reset are not routed. Memory must be reset together with this block.
- The combinational paths run `req_val` -> `mem_req_val`, `mem_req_rdy` -> `req_rdy`, and `resp_rdy` -> `mem_resp_rdy`. There is no path from `mem_resp_*` to `req_*`.
- Sustained throughput is one request and one response per cycle, limited by p_max_outst and the memory round-trip latency.

## Test plan
- **Single requester:** reset; port 0 sends read addr 0x1000, memory latency 1.
  - Required: `mem_req_msg.addr` = 0x1000 in the same cycle, `num_outst` 0 -> 1 -> 0.
  - Response data 0xCAFE appears on `resp_msg[0]`; `resp_val[1]` stays 0 throughout.
- **Round-robin fairness:** both ports hold `req_val` high for 8 cycles with `mem_req_rdy` = 1 and p_max_outst = 8.
  - Required: grant order 0,1,0,1,0,1,0,1.
  - Responses return to the ports in that same order.
- **Outstanding limit:** p_max_outst = 4, memory holds all responses.
  - Required: exactly 4 requests fire, then all `req_rdy` are 0 while `num_outst` = 4.
  - After one response pops, the next request fires one cycle later, not in the same cycle.
- **Response backpressure:** the head's requester (port 1) holds `resp_rdy` = 0 for 5 cycles.
  - Required: `mem_resp_rdy` = 0 for those 5 cycles; `resp_val[0]` stays 0.
  - Then the response delivers to port 1 and routing advances.
- **Memory request stall:** `mem_req_rdy` = 0 for 3 cycles while ports 0 and 1 are both valid and `rr_ptr` = 1.
  - Required: port 1 remains the winner throughout and fires first when `mem_req_rdy` rises; `rr_ptr` then becomes 0.
- **Asynchronous reset:** assert `reset` low between clock edges with 3 outstanding requests.
  - Required: `num_outst` = 0 and `mem_resp_rdy` = 0 immediately, without waiting for a clock edge; `rr_ptr` = 0 after release.
